multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle variant of the RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Is the producer side of the ALU control interface: drives the 4-bit ALU operation code and consumes the ALU Zero flag.
- Also drives the datapath mux selects, the write enables and the memory handshake.

---
 rtl/rv_ctrl_pkg.sv | 62 ++++++
 rtl/alu_op_dec.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared ALU codes, opcodes, FSM states and mux encodings for the multi-cycle RV32I core
package rv_ctrl_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_BNE  = 4'd10;
  localparam logic [3:0] ALU_BLT  = 4'd11;
  localparam logic [3:0] ALU_BGE  = 4'd12;
  localparam logic [3:0] ALU_BLTU = 4'd13;
  localparam logic [3:0] ALU_BGEU = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] SRCA_PC       = 2'd0;
  localparam logic [1:0] SRCA_OLDPC    = 2'd1;
  localparam logic [1:0] SRCA_RS1      = 2'd2;
  localparam logic [1:0] SRCA_ZERO     = 2'd3;
  localparam logic [1:0] SRCB_RS2      = 2'd0;
  localparam logic [1:0] SRCB_IMM      = 2'd1;
  localparam logic [1:0] SRCB_FOUR     = 2'd2;
  localparam logic [2:0] IMM_I         = 3'd0;
  localparam logic [2:0] IMM_S         = 3'd1;
  localparam logic [2:0] IMM_B         = 3'd2;
  localparam logic [2:0] IMM_J         = 3'd3;
  localparam logic [2:0] IMM_U         = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_JAL, S_JALR, S_BRANCH, S_UPPER, S_TRAP
  } state_t;

  typedef enum logic [1:0] {OPC_ADD, OPC_R, OPC_I, OPC_BR} op_class_t;

  // funct3 010/011 are not defined for branches
  function automatic logic branch_f3_legal(input logic [2:0] funct3);
    return !(funct3 == 3'b010 || funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// rtl/alu_op_dec.sv - maps (state class, funct3, funct7b5) to the ALU operation code
module alu_op_dec
  import rv_ctrl_pkg::*;
(
  input  op_class_t    op_class,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  output logic [3:0]   alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (op_class)
      OPC_R, OPC_I: begin
        case (funct3)
          // immediates carry no SUB form, so bit 30 only matters for R-type here
          3'b000:  alu_op = (op_class == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_BR: begin
        case (funct3)
          3'b000:  alu_op = ALU_SUB;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          3'b110:  alu_op = ALU_BLTU;
          3'b111:  alu_op = ALU_BGEU;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic               reg_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
);

  state_t    state;
  op_class_t op_class;
  logic [3:0] dec_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXEC_R;
            OP_I:              state <= S_EXEC_I;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_BRANCH:         state <= S_BRANCH;
            OP_LUI, OP_AUIPC:  state <= S_UPPER;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_UPPER: state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= branch_f3_legal(funct3) ? S_FETCH : S_TRAP;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_EXEC_R: op_class = OPC_R;
      S_EXEC_I: op_class = OPC_I;
      S_BRANCH: op_class = OPC_BR;
      default:  op_class = OPC_ADD;
    endcase
  end

  alu_op_dec u_alu_op_dec (
    .op_class (op_class),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_op   (dec_op)
  );

  // Outputs are forced low on the reset cycle so an abandoned instruction never writes
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    reg_write  = 1'b0;
    alu_op     = '0;
    illegal    = 1'b0;
    if (!rst) begin
      alu_op = ALUOP_W'(dec_op);
      case (state)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = (opcode == OP_JALR) ? SRCB_FOUR : SRCB_IMM;
          imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD:  adr_src = ADR_ALUOUT;
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = ADR_ALUOUT;
          mem_write = 1'b1;
        end
        S_EXEC_R:   alu_src_a = SRCA_RS1;
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_ALUWB:    reg_write = 1'b1;
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALURESULT;
          pc_write   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          pc_write  = zero && branch_f3_legal(funct3);
        end
        S_UPPER: begin
          alu_src_a = (opcode == OP_AUIPC) ? SRCA_OLDPC : SRCA_ZERO;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
        S_TRAP:     illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready, funct7b5;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_op;
  int         checks = 0;
  int         failures = 0;

  multicycle_ctrl #(.ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                     alu_src_b, imm_src, reg_write, alu_op, illegal};

  function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic rw,
                                     input logic [3:0] op, input logic ill);
    return {pcw, adr, mw, irw, res, sa, sb, imm, rw, op, ill};
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic exp);
    #1;
    checks++;
    assert (o === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic st(input string tag, input logic [18:0] exp);
    chk(tag, exp);
    cyc();
  endtask

  localparam logic [18:0] ZERO_OUT  = 19'h0;
  localparam logic [18:0] FETCH_GO  = {1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 3'd0, 1'b0, 4'd0, 1'b0};
  localparam logic [18:0] FETCH_WT  = {1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, 1'b0, 4'd0, 1'b0};
  localparam logic [18:0] DECODE_B  = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd2, 1'b0, 4'd0, 1'b0};
  localparam logic [18:0] ALUWB     = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 4'd0, 1'b0};
  localparam logic [18:0] TRAP      = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 4'd0, 1'b1};

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1;
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc();
    st("reset_cycle0", ZERO_OUT);
    st("reset_cycle1", ZERO_OUT);

    // R-type SUB: 4 cycles
    rst = 1'b0;
    st("r_fetch", FETCH_GO);
    st("r_decode", DECODE_B);
    st("r_exec_sub", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 0, 4'd1, 0));
    st("r_aluwb", ALUWB);

    // Load with a fetch wait and three memory wait cycles
    opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0;
    st("ld_fetch_wait", FETCH_WT);
    mem_ready = 1'b1;
    st("ld_fetch", FETCH_GO);
    st("ld_decode", DECODE_B);
    st("ld_memadr", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 4'd0, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      st("ld_memread_wait", mk(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 4'd0, 0));
    mem_ready = 1'b1;
    st("ld_memread_done", mk(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 4'd0, 0));
    st("ld_memwb", mk(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 1, 4'd0, 0));
    chk1("ld_no_second_regwrite", reg_write, 1'b0);

    // Store, reset arrives during MEMWRITE
    opcode = 7'b0100011;
    st("st_fetch", FETCH_GO);
    st("st_decode", DECODE_B);
    st("st_memadr_s", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 0, 4'd0, 0));
    mem_ready = 1'b0;
    chk("st_memwrite", mk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 4'd0, 0));
    rst = 1'b1;
    st("st_rst_in_memwrite", ZERO_OUT);
    rst = 1'b0;
    st("st_after_rst_fetch", FETCH_WT);
    mem_ready = 1'b1;

    // BNE taken, BNE not taken, BGEU
    opcode = 7'b1100011; funct3 = 3'b001; zero = 1'b1;
    st("bne_fetch", FETCH_GO);
    st("bne_decode", DECODE_B);
    st("bne_taken", mk(1, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 0, 4'd10, 0));
    zero = 1'b0;
    cyc(); cyc();
    st("bne_not_taken", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 0, 4'd10, 0));
    funct3 = 3'b111;
    cyc(); cyc();
    st("bgeu_op", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 0, 4'd14, 0));

    // I-type SRAI, then ADDI with bit 30 set
    opcode = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
    cyc(); cyc();
    st("srai_op", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 4'd7, 0));
    st("srai_aluwb", ALUWB);
    funct3 = 3'b000;
    cyc(); cyc();
    st("addi_not_sub", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 4'd0, 0));
    cyc();

    // JAL, JALR, LUI
    opcode = 7'b1101111;
    cyc();
    st("jal_decode_j", mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd3, 0, 4'd0, 0));
    st("jal_state", mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0, 4'd0, 0));
    st("jal_aluwb", ALUWB);
    opcode = 7'b1100111;
    cyc();
    st("jalr_decode", mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd2, 0, 4'd0, 0));
    st("jalr_state", mk(1, 0, 0, 0, 2'd2, 2'd2, 2'd1, 3'd0, 0, 4'd0, 0));
    cyc();
    opcode = 7'b0110111;
    cyc(); cyc();
    st("lui_upper", mk(0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd4, 0, 4'd0, 0));
    st("lui_aluwb", ALUWB);

    // Illegal opcode traps and stays until reset
    opcode = 7'b0000000;
    st("bad_fetch", FETCH_GO);
    st("bad_decode", DECODE_B);
    for (int i = 0; i < 3; i++) st("trap_hold", TRAP);
    rst = 1'b1;
    st("trap_rst", ZERO_OUT);
    rst = 1'b0;
    st("trap_cleared_fetch", FETCH_GO);

    // Undefined branch funct3 traps without writing the PC
    opcode = 7'b1100011; funct3 = 3'b010; zero = 1'b1;
    cyc();
    chk1("bad_branch_no_pcwrite", pc_write, 1'b0);
    cyc();
    st("bad_branch_trap", TRAP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
